// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, 2-entry {pc,instr} skid buffer, redirect flush; optional counter under FETCH_PERF_CNT_EN
module instr_fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [31:0]           fetch_count
);

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK       = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]            count_q, count_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] pc_mem_q    [2];
   logic [DATA_WIDTH-1:0] instr_mem_q [2];

   logic push;
   logic pop;

   // Memory address comes straight from the PC register; it is always word aligned.
   assign instr_addr = fetch_pc_q;

   // A redirect cycle hides the head so nothing is transferred while the buffer is flushed.
   assign out_valid = (count_q != 2'd0) && !redirect_valid;
   assign pop       = out_valid && out_ready;
   assign push      = !redirect_valid && ((count_q != 2'd2) || pop);

   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];

   // Next-state for PC, occupancy and pointers; redirect overrides push and pop.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         count_d    = 2'd0;
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            wr_ptr_d   = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC_ALIGNED;
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Buffer payload needs no reset: it is only observed while its entry is counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= instr;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;

   // Delivered-instruction counter; survives redirects, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count_q <= 32'h0;
      end else if (pop) begin
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table vectors, corner sequences and randomized model check for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_addr;
   logic [31:0] instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   // Reference model: next PC to deliver, number of fetched-but-undelivered words, pops since reset.
   logic [31:0] m_pc;
   int          m_occ;
   int          m_pops;

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einstr;
      logic [31:0] eaddr;
   } vec_t;

   vec_t tbl [14];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   assign instr = mem_word(instr_addr);

   instr_fetch_unit #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_addr    (instr_addr),
      .instr         (instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_instr     (out_instr),
      .fetch_count   (fetch_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef FETCH_PERF_CNT_EN
      return 32'(m_pops);
`else
      return 32'h0;
`endif
   endfunction

   // Drive inputs for the current cycle and let combinational outputs settle.
   task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
   endtask

   // Compare DUT against the stream model, advance the model, then clock.
   task automatic step_model();
      logic exp_v;
      logic pop;
      exp_v = (m_occ > 0) && !redirect_valid;
      chk("out_valid", out_valid, exp_v);
      chk("instr_addr", instr_addr, m_pc + 32'(4 * m_occ));
      chk("fetch_count", fetch_count, exp_count());
      pop = exp_v && out_ready;
      if (pop) begin
         chk("out_pc", out_pc, m_pc);
         chk("out_instr", out_instr, mem_word(m_pc));
      end
      if (redirect_valid) begin
         m_pc  = redirect_pc & 32'hFFFF_FFFC;
         m_occ = 0;
      end else begin
         if (pop) begin
            m_pc   = m_pc + 32'd4;
            m_occ  = m_occ - 1;
            m_pops = m_pops + 1;
         end
         if (m_occ < 2) m_occ = m_occ + 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
      drive(rv, rpc, rdy);
      step_model();
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_occ  = 0;
      m_pops = 0;
   endtask

   // Leaves the bench at posedge+1 of cycle 0 with reset released.
   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      tbl[0]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0000};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1000_0000, 32'h0000_0004};
      tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         32'h1000_0001, 32'h0000_0008};
      tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         32'h1000_0002, 32'h0000_000C};
      tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h1000_0003, 32'h0000_0010};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h1000_0003, 32'h0000_0014};
      tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h1000_0003, 32'h0000_0014};
      tbl[7]  = '{1'b1, 32'h203,       1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0014};
      tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0200};
      tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h200,       32'h1000_0080, 32'h0000_0204};
      tbl[10] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0208};
      tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC};
      tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 32'h0000_0000};
      tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'h1000_0000, 32'h0000_0004};

      // Table-driven sequence: streaming, stall, redirect while full, wrap-around redirect.
      do_reset();
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_addr", instr_addr, 32'h0);
      chk("reset_count", fetch_count, 32'h0);
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_addr", i), instr_addr, tbl[i].eaddr);
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].einstr);
         end
         step_model();
      end

      // Stall for 5 cycles from cycle 1, then release: 0x0, 0x4, 0x8 back-to-back.
      do_reset();
      step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b1);
      chk("stall_addr_hold", instr_addr, 32'h8);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         chk($sformatf("release%0d_valid", i), out_valid, 1'b1);
         chk($sformatf("release%0d_pc", i), out_pc, 32'(4 * i));
         step_model();
      end

      // Counter: 10 pops, a redirect, 3 more pops.
      do_reset();
      for (int i = 0; i < 11; i++) step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h0000_0400, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_count_13", fetch_count, 32'd13);
`else
      chk("perf_count_off", fetch_count, 32'd0);
`endif

      // Mid-stream reset with the buffer full.
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      chk("pre_reset_full_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_valid", out_valid, 1'b0);
      chk("async_reset_addr", instr_addr, 32'h0);
      chk("async_reset_count", fetch_count, 32'h0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      chk("post_reset_valid", out_valid, 1'b1);
      chk("post_reset_pc", out_pc, 32'h0);
      step_model();

      // Randomized traffic against the stream model.
      for (int i = 0; i < 3000; i++) begin
         logic        rv;
         logic [31:0] rpc;
         logic        rdy;
         rv  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            default: rpc = $urandom;
         endcase
         rdy = ($urandom_range(0, 9) < 7);
         step(rv, rpc, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side initiator for the combinational instruction memory: holds the fetch PC, drives a word-aligned `instr_addr`, captures the returned `instr` and hands {pc, instr} pairs to decode over a valid/ready handshake. A 2-entry skid buffer decouples memory reads from downstream stalls, sustaining one instruction per cycle. Branch/jump redirects flush the buffer and restart fetch from the new PC.

## Interface
- `DATA_WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 32, byte-address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] are ignored and treated as 0
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_addr`  out  ADDR_WIDTH  byte address to instruction memory; bits [1:0] always 0
- `instr`  in  DATA_WIDTH  word returned combinationally by instruction memory for `instr_addr`
- `redirect_valid`  in  1  flush and restart fetch this cycle
- `redirect_pc`  in  ADDR_WIDTH  new fetch address; bits [1:0] forced to 0
- `out_valid`  out  1  buffer head holds a valid instruction
- `out_ready`  in  1  decode accepts head this cycle
- `out_pc`  out  ADDR_WIDTH  PC of head instruction
- `out_instr`  out  DATA_WIDTH  head instruction word
- `fetch_count`  out  32  delivered-instruction counter (see Configuration)

## Operation
- State: `fetch_pc` register, 2-entry FIFO of {pc, instr}, 2-bit occupancy count (0..2), 1-bit read/write pointers.
- `instr_addr` = {`fetch_pc`[ADDR_WIDTH-1:2], 2'b00}, combinational from register.
- pop = `out_valid` && `out_ready`.
- push = !`redirect_valid` && (count < 2 || pop); push writes {`fetch_pc`, `instr`} at write pointer and `fetch_pc` <= `fetch_pc` + 4.
- `fetch_pc` increment wraps modulo 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0000_0000), no flag.
- `out_valid` = (count != 0) && !`redirect_valid`; no transfer occurs in a redirect cycle.
- Redirect (priority over everything): count <= 0, pointers <= 0, `fetch_pc` <= {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}; no push, no pop.
- Full with simultaneous pop: push and pop both occur, count stays 2.
- Empty: `out_pc`/`out_instr` are don't-care; only `out_valid` is defined.
- Reset (asserted any time, including mid-stream): `fetch_pc` = RESET_PC aligned, count = 0, pointers = 0, `out_valid` = 0, `fetch_count` = 0; buffered entries discarded.

## Timing
- Cycle 0 after `rst_n` rises: `instr_addr` = RESET_PC, `out_valid` = 0.
- Fetch-to-output latency: 1 cycle (address in cycle n -> `out_valid` with that PC in cycle n+1).
- Throughput: 1 instruction/cycle with `out_ready` held high.
- `out_ready` low: buffer fills in 2 cycles; fetch then holds `fetch_pc`, `instr_addr` stable until a pop.
- Redirect in cycle k: `instr_addr` = `redirect_pc` in cycle k+1; first redirected instruction valid in cycle k+2.
- Combinational paths: `instr` -> FIFO write data only; `redirect_valid` -> `out_valid`; `out_ready` -> push enable.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- Defined: `fetch_count` increments by 1 on every pop, wraps at 2^32, cleared only by reset (not by redirect).
- Undefined: counter not instantiated; `fetch_count` tied to 32'h0.

## Test plan
- Reset then `out_ready`=1, memory word i = 0x1000_0000+i: pops in cycles 1,2,3 give (pc,instr) = (0x0,0x1000_0000),(0x4,0x1000_0001),(0x8,0x1000_0002).
- `out_ready`=0 for 5 cycles from cycle 1: count saturates at 2, `instr_addr` holds 0x8; on release, pops 0x0,0x4,0x8 back-to-back with no gap or duplicate.
- `redirect_valid` with `redirect_pc`=0x203 while buffer full: `out_valid`=0 that cycle, next cycle `instr_addr`=0x200, following cycle `out_pc`=0x200; stale 0x4/0x8 never delivered.
- Redirect to 0xFFFF_FFFC: delivered PCs 0xFFFF_FFFC then 0x0000_0000.
- Assert `rst_n`=0 mid-stream with 2 entries buffered: `out_valid` drops immediately, after release `out_pc`=RESET_PC first.
- With `FETCH_PERF_CNT_EN`: 10 pops, one redirect, 3 pops -> `fetch_count`=13; without macro `fetch_count`=0 throughout.
